ip_filter_ctrl: RTL and testbench
=================================

Name: ip_filter_ctrl

Overview:
Programmable IPv4 address filter controller on the GMAC receive byte stream, clocked by rxcoreclk.
- Extracts the 4-byte IP field at a fixed byte offset of each frame.
- Checks it against a small software-written rule table and issues one registered drop/pass verdict per frame.
- Keeps saturating frame and drop counters.
- Sits beside the receive datapath and drives the downstream drop logic.

Parameters:
NUM_RULES, 4, number of rule entries (power of 2, 2..8)
IDX_W, 2, log2(NUM_RULES)
IP_OFFSET, 26, byte index of the first IP byte; byte 0 is the first dvld-high byte of the frame
CNT_W, 16, width of the statistics counters

Ports:
rxcoreclk  in  1  clock
reset  in  1  synchronous, active-high
gmac_rx_data  in  8  receive byte
gmac_rx_dvld  in  1  byte valid; a high run is one frame, low ends the frame
cfg_we  in  1  rule write strobe
cfg_idx  in  IDX_W  rule index
cfg_ip  in  32  rule address, first wire byte in [31:24]
cfg_en  in  1  rule enable
cnt_clr  in  1  clear both counters
verdict_valid  out  1  one-cycle verdict pulse
verdict_drop  out  1  frame matched an enabled rule
verdict_rule  out  IDX_W  index of the matching rule
verdict_short  out  1  frame ended before the IP field was complete
pkt_cnt  out  CNT_W  frames with a verdict
drop_cnt  out  CNT_W  frames with verdict_drop=1

Behaviour:
- Reset values:
  - All outputs 0, counters 0.
  - All rules: en=0, ip=0.
  - State SYNC.
- States: SYNC, IDLE, HDR, IPCAP, DECIDE, WAIT_END.
- SYNC: wait for dvld=0, then go to IDLE. This prevents locking onto the middle of a frame after reset.
- IDLE:
  - On dvld=1, that byte is byte 0; byte counter set to 1; go to HDR.
  - If IP_OFFSET==0, go directly to IPCAP and capture byte 0.
- HDR:
  - Each dvld=1 cycle increments the byte counter.
  - When the counter reaches IP_OFFSET, go to IPCAP.
- IPCAP:
  - Shift 4 bytes into ip_reg, first byte into [31:24].
  - After the 4th byte, go to DECIDE.
- DECIDE (one cycle): compare ip_reg against every enabled rule; the lowest matching index wins.
- Verdict timing:
  - Byte 0 is sampled at edge 0, so the 4th IP byte is sampled at edge IP_OFFSET+3.
  - The verdict is registered at edge IP_OFFSET+4, and verdict_valid is high for exactly one cycle.
  - verdict_drop, verdict_rule and verdict_short hold their values until the next verdict.
  - verdict_rule=0 when there is no match.
- After DECIDE: dvld=1 goes to WAIT_END, dvld=0 goes to IDLE.
- WAIT_END: remain until dvld=0, then go to IDLE. A new frame can start on the cycle after dvld goes low.
- dvld=0 in HDR or IPCAP (short frame):
  - Next cycle: verdict_valid=1, verdict_short=1, drop=0, rule=0.
  - Go to IDLE.
  - pkt_cnt increments.
- Every verdict increments pkt_cnt. drop_cnt increments when drop=1.
- Counters saturate at all-ones.
- cnt_clr wins over a same-cycle increment.
- Config writes:
  - Take effect at the clock edge.
  - A write in the DECIDE cycle is not seen by that compare; the old table value is used.
  - A write to the matching entry in any earlier cycle is seen.
- Reset mid-frame: outputs and table cleared, state SYNC, no verdict for the interrupted frame.

Decomposition:
- Package ip_filter_pkg:
  - state encoding constants;
  - default IP_OFFSET (26);
  - rule entry record {en, ip[31:0]}.
- Sub-module ip_rule_cam:
  - rule table registers with write port;
  - combinational priority compare, outputs hit and hit_idx.
- ip_filter_ctrl keeps the FSM, byte counter, capture register, verdict registers and counters.

Test Plan:
- Rule0=C0A80178 enabled; 64-byte frame with bytes 26..29 = C0 A8 01 78 -> verdict_valid pulse at edge 30 with drop=1, rule=0, short=0; pkt_cnt=1, drop_cnt=1.
- Rules 1 and 3 both = 0A000001 enabled; frame carries 0A 00 00 01 -> drop=1, rule=1. Disable rule1 and resend -> rule=3.
- No rules enabled; frame carries C0 A8 01 78 -> drop=0. Frame ends at byte 27 -> short=1 one cycle after dvld falls; pkt_cnt +1, drop_cnt unchanged.
- Two back-to-back frames with one idle cycle between them -> two verdicts. Reset asserted at byte 10 of a frame -> no verdict; the frame after the next dvld low gets a correct verdict.
- drop_cnt preloaded to FFFF by repeated matches -> stays FFFF on further match. cnt_clr coincident with a verdict -> both counters 0.
- Rule0 written to the matching IP in the DECIDE cycle -> drop=0 for that frame; the next identical frame gives drop=1.

Source files
------------

// File: rtl/ip_filter_pkg.sv
// Shared types and defaults for the receive-side IPv4 address filter.
// Holds the controller state encoding and the rule table entry layout.
package ip_filter_pkg;

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StHdr,
        StIpcap,
        StDecide,
        StWaitEnd
    } state_e;

    localparam int unsigned DefaultIpOffset = 26;
    localparam int unsigned ByteCntW        = 16;

    typedef struct packed {
        logic        en;
        logic [31:0] ip;
    } rule_t;

endpackage

// File: rtl/ip_rule_cam.sv
// Software-written IPv4 rule table with a combinational priority match.
// When several enabled entries match, the lowest index is reported.
module ip_rule_cam
    import ip_filter_pkg::*;
#(
    parameter int unsigned NUM_RULES = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic             rxcoreclk,
    input  logic             reset,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_idx_i,
    input  logic [31:0]      cfg_ip_i,
    input  logic             cfg_en_i,
    input  logic [31:0]      key_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] hit_idx_o
);

    rule_t rules_q [NUM_RULES];

    always_ff @(posedge rxcoreclk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_RULES); i++) begin
                rules_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            rules_q[cfg_idx_i] <= '{en: cfg_en_i, ip: cfg_ip_i};
        end
    end

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
            if (rules_q[i].en && (rules_q[i].ip == key_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ip_filter_ctrl.sv
// IPv4 address filter controller: captures the IP field of each received frame,
// matches it against the rule table and issues one registered verdict per frame.
module ip_filter_ctrl
    import ip_filter_pkg::*;
#(
    parameter int unsigned NUM_RULES = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned IP_OFFSET = DefaultIpOffset,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             rxcoreclk,
    input  logic             reset,
    input  logic [7:0]       gmac_rx_data,
    input  logic             gmac_rx_dvld,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_ip,
    input  logic             cfg_en,
    input  logic             cnt_clr,
    output logic             verdict_valid,
    output logic             verdict_drop,
    output logic [IDX_W-1:0] verdict_rule,
    output logic             verdict_short,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [ByteCntW-1:0] OffsetCnt = ByteCntW'(IP_OFFSET);

    state_e              state_q;
    logic [ByteCntW-1:0] byte_cnt_q;
    logic [1:0]          ip_cnt_q;
    logic [31:0]         ip_reg_q;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                verdict_fire;
    logic                verdict_hit;

    ip_rule_cam #(
        .NUM_RULES (NUM_RULES),
        .IDX_W     (IDX_W)
    ) u_cam (
        .rxcoreclk (rxcoreclk),
        .reset     (reset),
        .cfg_we_i  (cfg_we),
        .cfg_idx_i (cfg_idx),
        .cfg_ip_i  (cfg_ip),
        .cfg_en_i  (cfg_en),
        .key_i     (ip_reg_q),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    // A frame dropping dvld before its IP field is complete still gets a verdict.
    assign verdict_fire = (state_q == StDecide) ||
                          (!gmac_rx_dvld && ((state_q == StHdr) || (state_q == StIpcap)));
    assign verdict_hit  = (state_q == StDecide) && hit;

    always_ff @(posedge rxcoreclk) begin
        if (reset) begin
            state_q       <= StSync;
            byte_cnt_q    <= '0;
            ip_cnt_q      <= '0;
            ip_reg_q      <= '0;
            verdict_valid <= 1'b0;
            verdict_drop  <= 1'b0;
            verdict_rule  <= '0;
            verdict_short <= 1'b0;
        end else begin
            verdict_valid <= verdict_fire;
            if (verdict_fire) begin
                verdict_drop  <= verdict_hit;
                verdict_rule  <= verdict_hit ? hit_idx : '0;
                verdict_short <= (state_q != StDecide);
            end

            unique case (state_q)
                StSync: begin
                    if (!gmac_rx_dvld) state_q <= StIdle;
                end
                StIdle: begin
                    if (gmac_rx_dvld) begin
                        byte_cnt_q <= ByteCntW'(1);
                        if (IP_OFFSET == 0) begin
                            ip_reg_q <= {24'h0, gmac_rx_data};
                            ip_cnt_q <= 2'd1;
                            state_q  <= StIpcap;
                        end else if (IP_OFFSET == 1) begin
                            ip_cnt_q <= 2'd0;
                            state_q  <= StIpcap;
                        end else begin
                            state_q  <= StHdr;
                        end
                    end
                end
                StHdr: begin
                    if (!gmac_rx_dvld) begin
                        state_q <= StIdle;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + ByteCntW'(1);
                        if (byte_cnt_q + ByteCntW'(1) == OffsetCnt) begin
                            ip_cnt_q <= 2'd0;
                            state_q  <= StIpcap;
                        end
                    end
                end
                StIpcap: begin
                    if (!gmac_rx_dvld) begin
                        state_q <= StIdle;
                    end else begin
                        ip_reg_q <= {ip_reg_q[23:0], gmac_rx_data};
                        ip_cnt_q <= ip_cnt_q + 2'd1;
                        if (ip_cnt_q == 2'd3) state_q <= StDecide;
                    end
                end
                StDecide: begin
                    state_q <= gmac_rx_dvld ? StWaitEnd : StIdle;
                end
                StWaitEnd: begin
                    if (!gmac_rx_dvld) state_q <= StIdle;
                end
                default: state_q <= StSync;
            endcase
        end
    end

    always_ff @(posedge rxcoreclk) begin
        if (reset || cnt_clr) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (verdict_fire && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (verdict_hit && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ip_filter_ctrl.sv
// Self-checking bench for ip_filter_ctrl: directed scenarios plus randomized frames,
// compared every cycle against a frame-level reference model.
module tb_ip_filter_ctrl;

    localparam int unsigned NR   = 4;
    localparam int unsigned IW   = 2;
    localparam int unsigned OFF  = 26;
    localparam int unsigned CW   = 6;
    localparam int          CMAX = (1 << CW) - 1;

    logic          rxcoreclk = 1'b0;
    logic          reset;
    logic [7:0]    gmac_rx_data;
    logic          gmac_rx_dvld;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [31:0]   cfg_ip;
    logic          cfg_en;
    logic          cnt_clr;
    logic          verdict_valid;
    logic          verdict_drop;
    logic [IW-1:0] verdict_rule;
    logic          verdict_short;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;

    ip_filter_ctrl #(
        .NUM_RULES (NR),
        .IDX_W     (IW),
        .IP_OFFSET (OFF),
        .CNT_W     (CW)
    ) dut (
        .rxcoreclk     (rxcoreclk),
        .reset         (reset),
        .gmac_rx_data  (gmac_rx_data),
        .gmac_rx_dvld  (gmac_rx_dvld),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_ip        (cfg_ip),
        .cfg_en        (cfg_en),
        .cnt_clr       (cnt_clr),
        .verdict_valid (verdict_valid),
        .verdict_drop  (verdict_drop),
        .verdict_rule  (verdict_rule),
        .verdict_short (verdict_short),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 rxcoreclk = ~rxcoreclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_en [NR];
    logic [31:0] m_ip [NR];
    int          m_pkt, m_drop, m_rule;
    logic        m_valid, m_vdrop, m_short;

    logic [31:0] pool [4] = '{32'hC0A80178, 32'h0A000001, 32'h11223344, 32'hAABBCCDD};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, 64'(verdict_valid), 64'(m_valid));
        check_eq({tag, ".drop"},  64'(verdict_drop),  64'(m_vdrop));
        check_eq({tag, ".rule"},  64'(verdict_rule),  64'(m_rule));
        check_eq({tag, ".short"}, 64'(verdict_short), 64'(m_short));
        check_eq({tag, ".pkt"},   64'(pkt_cnt),       64'(m_pkt));
        check_eq({tag, ".dropc"}, 64'(drop_cnt),      64'(m_drop));
    endtask

    function automatic void model_lookup(input logic [31:0] key, output logic hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < int'(NR); i++) begin
            if (m_en[i] && (m_ip[i] == key)) begin
                hit = 1'b1;
                idx = i;
                break;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(NR); i++) begin
            m_en[i] = 1'b0;
            m_ip[i] = '0;
        end
        m_pkt = 0; m_drop = 0; m_rule = 0;
        m_valid = 1'b0; m_vdrop = 1'b0; m_short = 1'b0;
    endfunction

    function automatic void model_count(input logic fire, input logic hit, input logic clr);
        if (clr) begin
            m_pkt  = 0;
            m_drop = 0;
        end else begin
            if (fire && m_pkt < CMAX) m_pkt++;
            if (fire && hit && m_drop < CMAX) m_drop++;
        end
    endfunction

    // One cycle with no frame activity expected to produce a verdict.
    task automatic raw_cycle(input logic dvld, input logic rst, input logic we, input int idx,
                             input logic [31:0] ip, input logic en, input logic clr);
        reset        = rst;
        gmac_rx_dvld = dvld;
        gmac_rx_data = 8'($urandom);
        cfg_we = we; cfg_idx = IW'(idx); cfg_ip = ip; cfg_en = en; cnt_clr = clr;
        @(posedge rxcoreclk);
        if (rst) begin
            model_clear();
        end else begin
            m_valid = 1'b0;
            model_count(1'b0, 1'b0, clr);
            if (we) begin
                m_en[idx] = en;
                m_ip[idx] = ip;
            end
        end
        #1 check_outputs("idle");
        cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] ip, input logic en);
        raw_cycle(1'b0, 1'b0, 1'b1, idx, ip, en, 1'b0);
    endtask

    // Drives len valid bytes then one idle cycle; key lands at bytes OFF..OFF+3.
    task automatic send_frame(input int len, input logic [31:0] key, input int cfg_edge,
                              input int c_idx, input logic [31:0] c_ip, input logic c_en,
                              input int clr_edge, input int clr_pct);
        logic hit, fire, shrt, clr;
        int   idx;
        for (int e = 0; e <= len; e++) begin
            gmac_rx_dvld = (e < len);
            if (e >= int'(OFF) && e < int'(OFF) + 4)
                gmac_rx_data = 8'(key >> (8 * (3 - (e - int'(OFF)))));
            else
                gmac_rx_data = 8'($urandom);
            cfg_we = (e == cfg_edge); cfg_idx = IW'(c_idx); cfg_ip = c_ip; cfg_en = c_en;
            clr = (e == clr_edge) || (int'($urandom_range(99)) < clr_pct);
            cnt_clr = clr;
            @(posedge rxcoreclk);
            hit = 1'b0; idx = 0; fire = 1'b0; shrt = 1'b0;
            if (len >= int'(OFF) + 4 && e == int'(OFF) + 4) begin
                model_lookup(key, hit, idx);
                fire = 1'b1;
            end else if (len < int'(OFF) + 4 && e == len) begin
                fire = 1'b1;
                shrt = 1'b1;
            end
            m_valid = fire;
            if (fire) begin
                m_vdrop = hit;
                m_rule  = hit ? idx : 0;
                m_short = shrt;
            end
            model_count(fire, hit, clr);
            if (e == cfg_edge) begin
                m_en[c_idx] = c_en;
                m_ip[c_idx] = c_ip;
            end
            #1 check_outputs("frame");
        end
        cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len, ce, ci;
        reset = 1'b1; gmac_rx_dvld = 1'b0; gmac_rx_data = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_ip = '0; cfg_en = 1'b0; cnt_clr = 1'b0;
        model_clear();
        repeat (3) raw_cycle(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        check_eq("reset.pkt", 64'(pkt_cnt), 64'd0);
        repeat (2) raw_cycle(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);

        // Single rule hit on a 64-byte frame
        cfg_write(0, 32'hC0A80178, 1'b1);
        send_frame(64, 32'hC0A80178, -1, 0, 0, 0, -1, 0);
        check_eq("t1.drop", 64'(verdict_drop), 64'd1);
        check_eq("t1.pkt", 64'(pkt_cnt), 64'd1);
        check_eq("t1.dropc", 64'(drop_cnt), 64'd1);

        // Priority between duplicate rules, then fall-through to rule 3
        cfg_write(1, 32'h0A000001, 1'b1);
        cfg_write(3, 32'h0A000001, 1'b1);
        send_frame(40, 32'h0A000001, -1, 0, 0, 0, -1, 0);
        check_eq("t2.rule1", 64'(verdict_rule), 64'd1);
        cfg_write(1, 32'h0A000001, 1'b0);
        send_frame(40, 32'h0A000001, -1, 0, 0, 0, -1, 0);
        check_eq("t2.rule3", 64'(verdict_rule), 64'd3);

        // No enabled rules, then a short frame ending at byte 27
        for (int i = 0; i < int'(NR); i++) cfg_write(i, pool[i % 4], 1'b0);
        send_frame(30, 32'hC0A80178, -1, 0, 0, 0, -1, 0);
        check_eq("t3.nodrop", 64'(verdict_drop), 64'd0);
        send_frame(28, 32'hC0A80178, -1, 0, 0, 0, -1, 0);
        check_eq("t3.short", 64'(verdict_short), 64'd1);
        check_eq("t3.dropc", 64'(drop_cnt), 64'd3);

        // Reset at byte 10, frame keeps running into SYNC
        cfg_write(2, 32'h11223344, 1'b1);
        for (int e = 0; e < 10; e++) raw_cycle(1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        repeat (2) raw_cycle(1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        repeat (40) raw_cycle(1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        raw_cycle(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        cfg_write(2, 32'h11223344, 1'b1);
        send_frame(34, 32'h11223344, -1, 0, 0, 0, -1, 0);
        check_eq("t4.rule", 64'(verdict_rule), 64'd2);
        check_eq("t4.pkt", 64'(pkt_cnt), 64'd1);

        // Counter saturation and clear coincident with a verdict
        cfg_write(0, 32'hAABBCCDD, 1'b1);
        for (int n = 0; n < CMAX + 3; n++) send_frame(30, 32'hAABBCCDD, -1, 0, 0, 0, -1, 0);
        check_eq("t5.sat_drop", 64'(drop_cnt), 64'(CMAX));
        check_eq("t5.sat_pkt", 64'(pkt_cnt), 64'(CMAX));
        send_frame(30, 32'hAABBCCDD, -1, 0, 0, 0, int'(OFF) + 4, 0);
        check_eq("t5.clr_pkt", 64'(pkt_cnt), 64'd0);
        check_eq("t5.clr_drop", 64'(drop_cnt), 64'd0);

        // Rule write in the decide cycle is not seen by that frame
        cfg_write(0, 32'h0, 1'b0);
        cfg_write(2, 32'h0, 1'b0);
        send_frame(40, 32'h11223344, int'(OFF) + 4, 0, 32'h11223344, 1'b1, -1, 0);
        check_eq("t6.late", 64'(verdict_drop), 64'd0);
        send_frame(40, 32'h11223344, -1, 0, 0, 0, -1, 0);
        check_eq("t6.next", 64'(verdict_drop), 64'd1);

        // Randomized frames, mid-frame writes and sporadic clears
        for (int n = 0; n < 150; n++) begin
            len = int'($urandom_range(70, 1));
            ce  = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(len, 0));
            ci  = int'($urandom_range(NR - 1));
            send_frame(len, pool[$urandom_range(3)], ce, ci, pool[$urandom_range(3)],
                       1'($urandom), -1, 2);
            if ($urandom_range(3) == 0) begin
                cfg_write(int'($urandom_range(NR - 1)), pool[$urandom_range(3)], 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
